// File: rtl/div_unit.sv
// div_unit: multicycle restoring divider for div/divu.
// One quotient bit per clock; HI = remainder, LO = quotient.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       ctl,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [5:0] CTL_DIV  = 6'd26;
    localparam logic [5:0] CTL_DIVU = 6'd27;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   acc_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;

    assign accept = start && (ctl == CTL_DIV || ctl == CTL_DIVU);
    assign sgn    = (ctl == CTL_DIV);
    assign a_neg  = sgn & dividend[WIDTH-1];
    assign b_neg  = sgn & divisor[WIDTH-1];

    // The accumulator holds a remainder < |divisor|, so after the shift
    // it needs one extra bit; the difference fits back into WIDTH bits.
    assign acc_sh = {acc_q, dq_q[WIDTH-1]};
    assign ge     = (acc_sh >= {1'b0, dvsr_q});
    assign diff   = acc_sh[WIDTH-1:0] - dvsr_q;
    assign q_next = {dq_q[WIDTH-2:0], ge};
    assign r_next = ge ? diff : acc_sh[WIDTH-1:0];

    // Next-state and datapath update for the IDLE/RUN/DONE sequence
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        dq_d    = dq_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    dq_d   = a_neg ? -dividend : dividend;
                    dvsr_d = b_neg ? -divisor : divisor;
                    acc_d  = '0;
                    cnt_d  = '0;
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = r_next;
                dq_d  = q_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    quot_d  = negq_q ? -q_next : q_next;
                    rem_d   = negr_q ? -r_next : r_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            dq_q    <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            dq_q    <= dq_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit.
// Directed vectors; a negedge monitor checks each done pulse.
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [5:0]   ctl = '0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t sbq[$];
    int   nvec = 0;
    int   nerr = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .ctl(ctl),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r,
                                input logic z);
        exp_t e;
        e.q = q;
        e.r = r;
        e.z = z;
        return e;
    endfunction

    // Monitor: every done pulse consumes one scoreboard entry
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_done: got done=1 want no pending op");
            end else begin
                e = sbq.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", W'(div_by_zero), W'(e.z));
            end
        end
    end

    task automatic run_op(input logic [5:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input exp_t e,
                          input int exp_lat, input bit inject);
        int lat;
        int bcyc;
        bit seen;
        exp_t dropped;
        @(negedge clk);
        start = 1'b1;
        ctl = c;
        dividend = a;
        divisor = b;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        ctl = '0;
        dividend = $urandom;
        divisor = $urandom;
        lat = 0;
        bcyc = 0;
        seen = 1'b0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            @(negedge clk);
            if (inject && i == 5) begin
                start = 1'b1;
                ctl = 6'd27;
                dividend = 32'd999;
                divisor = 32'd3;
            end else if (inject && i == 6) begin
                start = 1'b0;
            end
            if (busy) bcyc++;
            if (done) begin
                seen = 1'b1;
                lat = i;
            end
        end
        if (!seen) begin
            nvec++;
            nerr++;
            $display("FAIL timeout: got no done want done within 100 cycles");
            if (sbq.size() != 0) dropped = sbq.pop_front();
        end else begin
            check("latency", W'(lat), W'(exp_lat));
            check("busy_cycles", W'(bcyc), W'(exp_lat - 1));
            if (inject) begin
                start = 1'b1;
                ctl = 6'd27;
                dividend = 32'd40;
                divisor = 32'd4;
            end
            @(negedge clk);
            start = 1'b0;
            check("done_pulse", W'(done), W'(0));
            check("busy_after_done", W'(busy), W'(0));
        end
    endtask

    initial begin
        #12;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_quot", quotient, '0);
        check("rst_rem", remainder, '0);
        check("rst_dbz", W'(div_by_zero), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op(6'd27, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0), 33, 1'b0);
        run_op(6'd26, 32'hFFFFFFF9, 32'd2,
               mk(32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0), 33, 1'b0);
        run_op(6'd26, 32'd7, 32'hFFFFFFFE,
               mk(32'hFFFFFFFD, 32'd1, 1'b0), 33, 1'b0);
        run_op(6'd26, 32'hFFFFFF9C, 32'd7,
               mk(32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0), 33, 1'b0);
        run_op(6'd26, 32'h80000000, 32'hFFFFFFFF,
               mk(32'h80000000, 32'd0, 1'b0), 33, 1'b0);
        run_op(6'd27, 32'hFFFFFFFF, 32'd1,
               mk(32'hFFFFFFFF, 32'd0, 1'b0), 33, 1'b0);
        run_op(6'd27, 32'h1234, 32'd0,
               mk(32'hFFFFFFFF, 32'h1234, 1'b1), 1, 1'b0);
        run_op(6'd27, 32'd9, 32'd3, mk(32'd3, 32'd0, 1'b0), 33, 1'b0);
        run_op(6'd26, 32'hFFFFFFFB, 32'd0,
               mk(32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1), 1, 1'b0);
        run_op(6'd27, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0), 33, 1'b1);

        // Unsupported function code must never start anything
        @(negedge clk);
        start = 1'b1;
        ctl = 6'd34;
        dividend = 32'd5;
        divisor = 32'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            check("ctl34_busy", W'(busy), W'(0));
            check("ctl34_done", W'(done), W'(0));
        end
        check("ctl34_quot", quotient, 32'd14);
        check("ctl34_rem", remainder, 32'd2);

        // Asynchronous reset in the middle of an iteration
        @(negedge clk);
        start = 1'b1;
        ctl = 6'd27;
        dividend = 32'd100;
        divisor = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", W'(busy), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", W'(busy), W'(0));
        check("arst_done", W'(done), W'(0));
        check("arst_quot", quotient, '0);
        check("arst_rem", remainder, '0);
        check("arst_dbz", W'(div_by_zero), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op(6'd27, 32'd50, 32'd5, mk(32'd10, 32'd0, 1'b0), 33, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", W'(sbq.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
